// File: rtl/vga_timing.sv
// Raster timing generator: free-running pixel/line counters, sync and blank
// strobes delayed to line up with the registered, blank-masked colour output.
module vga_timing #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int DRAW_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBin,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PIPE    = DRAW_LATENCY + 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        x_wrap;

  always_comb begin
    x_wrap = (x_q == H_LAST);
    x_d    = x_wrap ? 11'd0 : x_q + 11'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= 11'd0;
      y_q <= 11'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic hs_raw, vs_raw, bl_raw;

  always_comb begin
    hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
    vs_raw = !((y_q >= VS_START) && (y_q < VS_END));
    bl_raw = (x_q >= H_VIS) || (y_q >= V_VIS);
  end

  // Stage 0 holds the strobe for the current counter value; the last stage
  // lines up with the colour register fed by the downstream drawing pipeline.
  logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE-1:0] bl_pipe_q, bl_pipe_d;

  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    bl_pipe_d    = bl_pipe_q;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    bl_pipe_d[0] = bl_raw;
    for (int i = 1; i < PIPE; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      bl_pipe_d[i] = bl_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      bl_pipe_q <= '1;
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      bl_pipe_q <= bl_pipe_d;
    end
  end

  logic [11:0] rgb_q, rgb_d;

  // 3/3/2-bit channels widened to 4 bits by replicating their top bits.
  always_comb begin
    rgb_d = {RGBin[7:5], RGBin[7], RGBin[4:2], RGBin[4], RGBin[1:0], RGBin[1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 12'd0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  always_comb begin
    pixelX = x_q;
    pixelY = y_q;
    hsync  = hs_pipe_q[PIPE-1];
    vsync  = vs_pipe_q[PIPE-1];
    blank  = bl_pipe_q[PIPE-1];
    red    = blank ? 4'd0 : rgb_q[11:8];
    green  = blank ? 4'd0 : rgb_q[7:4];
    blue   = blank ? 4'd0 : rgb_q[3:0];
  end

  // Gated by reset so the origin cycle right after reset release already
  // reports a frame start, while cycles spent inside reset never do.
  always_comb begin
    startOfFrame = !reset && (x_q == 11'd0) && (y_q == 11'd0);
  end

endmodule
